// File: rtl/easyaxi_txn_sched.sv
// easyaxi_txn_sched: round-robin transaction scheduler sharing one EASYAXI_TOP
// read/write engine between REQ_NUM requesters. It holds the selected level
// enable until the matching done pulse or a timeout, then enforces an idle gap.
module easyaxi_txn_sched #(
    parameter int REQ_NUM = 2,
    parameter int GAP_CYC = 3,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] req,
    input  logic [REQ_NUM-1:0] req_wr,
    output logic [REQ_NUM-1:0] gnt,
    output logic [REQ_NUM-1:0] cpl,
    output logic               cpl_err,
    output logic               rd_en,
    input  logic               rd_done,
    output logic               wr_en,
    input  logic               wr_done,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_cnt
);

    localparam int PTR_W  = $clog2(REQ_NUM);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(REQ_NUM - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;      // last granted requester
    logic                dir_q, dir_d;      // 1 = write in flight
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [REQ_NUM-1:0]  gnt_q, gnt_d;
    logic [REQ_NUM-1:0]  cpl_q, cpl_d;
    logic                cpl_err_q, cpl_err_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    txn_cnt_q, txn_cnt_d;

    logic                req_found;
    logic [PTR_W-1:0]    sel;
    logic                done_match;

    // Round-robin pick: first set req bit searching upward from ptr+1, wrapping.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_found = 1'b0;
        sel       = ptr_q;
        idx       = 0;
        cand      = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            cand = PTR_W'(idx);
            if (!req_found && req[cand]) begin
                req_found = 1'b1;
                sel       = cand;
            end
        end
    end

    // Only the done pulse for the direction in flight ends a transaction.
    assign done_match = dir_q ? wr_done : rd_done;

    // Next-state and next-output logic for the IDLE/RUN/GAP sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dir_d     = dir_q;
        wait_d    = wait_q;
        gap_d     = gap_q;
        txn_cnt_d = txn_cnt_q;
        gnt_d     = '0;
        cpl_d     = '0;
        cpl_err_d = 1'b0;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;

        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    state_d    = S_RUN;
                    ptr_d      = sel;
                    dir_d      = req_wr[sel];
                    wait_d     = '0;
                    gnt_d[sel] = 1'b1;
                    rd_en_d    = ~req_wr[sel];
                    wr_en_d    = req_wr[sel];
                end
            end
            S_RUN: begin
                // A done arriving on the timeout cycle still counts as success.
                if (done_match || (wait_q == WAIT_MAX)) begin
                    state_d      = S_GAP;
                    gap_d        = '0;
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    cpl_d[ptr_q] = 1'b1;
                    if (done_match) begin
                        txn_cnt_d = txn_cnt_q + CNT_W'(1);
                    end else begin
                        cpl_err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                // Staying until the counter reaches GAP_CYC, plus the IDLE
                // cycle, gives GAP_CYC+2 cycles from enable fall to next rise.
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops enables and pulses at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            dir_q     <= 1'b0;
            wait_q    <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            cpl_q     <= '0;
            cpl_err_q <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            txn_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            dir_q     <= dir_d;
            wait_q    <= wait_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            cpl_q     <= cpl_d;
            cpl_err_q <= cpl_err_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign cpl     = cpl_q;
    assign cpl_err = cpl_err_q;
    assign rd_en   = rd_en_q;
    assign wr_en   = wr_en_q;
    assign busy    = busy_q;
    assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_easyaxi_txn_sched.sv
// Bench for easyaxi_txn_sched: unit 0 uses TIMEOUT=1024/CNT_W=16, unit 1 uses
// TIMEOUT=16/CNT_W=2. Grants and completions are scoreboarded through queues.
module tb_easyaxi_txn_sched;

    localparam int GAP = 3;

    typedef struct {
        logic [1:0] req;
        logic [1:0] req_wr;
        int         delay;
        bit         spur;
        logic [1:0] exp_gnt;
        bit         exp_wr;
    } vec_t;

    typedef struct {
        int         unit;
        logic [1:0] gnt;
        bit         rd;
        bit         wr;
    } exp_gnt_t;

    typedef struct {
        int         unit;
        logic [1:0] cpl;
        bit         err;
        int         cnt;
    } exp_cpl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req     [2];
    logic [1:0] req_wr  [2];
    logic [1:0] gnt     [2];
    logic [1:0] cpl     [2];
    logic       cpl_err [2];
    logic       rd_en   [2];
    logic       wr_en   [2];
    logic       rd_done [2];
    logic       wr_done [2];
    logic       busy    [2];
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    int model_cnt [2];
    int cnt_mod   [2] = '{65536, 4};

    exp_gnt_t gq[$];
    exp_cpl_t cq[$];

    always #5 clk = ~clk;

    easyaxi_txn_sched #(.REQ_NUM(2), .GAP_CYC(GAP), .TIMEOUT(1024), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .req_wr(req_wr[0]), .gnt(gnt[0]),
        .cpl(cpl[0]), .cpl_err(cpl_err[0]), .rd_en(rd_en[0]), .rd_done(rd_done[0]),
        .wr_en(wr_en[0]), .wr_done(wr_done[0]), .busy(busy[0]), .txn_cnt(cnt_a)
    );

    easyaxi_txn_sched #(.REQ_NUM(2), .GAP_CYC(GAP), .TIMEOUT(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .req_wr(req_wr[1]), .gnt(gnt[1]),
        .cpl(cpl[1]), .cpl_err(cpl_err[1]), .rd_en(rd_en[1]), .rd_done(rd_done[1]),
        .wr_en(wr_en[1]), .wr_done(wr_done[1]), .busy(busy[1]), .txn_cnt(cnt_b)
    );

    function automatic int get_cnt(input int u);
        return (u == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Scoreboard side: compare every grant and completion the DUTs produce.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            check("en_exclusive", longint'(rd_en[u] & wr_en[u]), 0);
            if (cpl[u] == 2'b00) check("cpl_err_qual", longint'(cpl_err[u]), 0);
            if (gnt[u] != 2'b00) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", longint'(gnt[u]), 0);
                end else begin
                    exp_gnt_t g;
                    g = gq.pop_front();
                    check("gnt_unit", u, g.unit);
                    check("gnt_val", longint'(gnt[u]), longint'(g.gnt));
                    check("gnt_rd_en", longint'(rd_en[u]), longint'(g.rd));
                    check("gnt_wr_en", longint'(wr_en[u]), longint'(g.wr));
                end
            end
            if (cpl[u] != 2'b00) begin
                if (cq.size() == 0) begin
                    check("cpl_unexpected", longint'(cpl[u]), 0);
                end else begin
                    exp_cpl_t c;
                    c = cq.pop_front();
                    check("cpl_unit", u, c.unit);
                    check("cpl_val", longint'(cpl[u]), longint'(c.cpl));
                    check("cpl_err", longint'(cpl_err[u]), longint'(c.err));
                    check("cpl_txn_cnt", get_cnt(u), c.cnt);
                end
            end
        end
    end

    task automatic push_gnt(input int u, input logic [1:0] g, input bit wr);
        gq.push_back('{u, g, !wr, wr});
    endtask

    task automatic push_cpl(input int u, input logic [1:0] c, input bit err);
        if (!err) model_cnt[u] = (model_cnt[u] + 1) % cnt_mod[u];
        cq.push_back('{u, c, err, model_cnt[u]});
    endtask

    task automatic pulse_done(input int u, input bit wr);
        if (wr) wr_done[u] = 1'b1;
        else    rd_done[u] = 1'b1;
        @(negedge clk);
        wr_done[u] = 1'b0;
        rd_done[u] = 1'b0;
    endtask

    task automatic wait_gnt(input int u);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt[u] == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (gnt[u] == 2'b00) fail("gnt_wait");
    endtask

    task automatic wait_cpl(input int u);
        int n;
        n = 0;
        while (cpl[u] == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (cpl[u] == 2'b00) fail("cpl_wait");
    endtask

    task automatic run_vec(input int u, input vec_t v);
        req[u]    = v.req;
        req_wr[u] = v.req_wr;
        push_gnt(u, v.exp_gnt, v.exp_wr);
        wait_gnt(u);
        for (int k = 0; k < v.delay; k++) begin
            @(negedge clk);
            if (v.spur && k == v.delay / 2) begin
                pulse_done(u, !v.exp_wr);
                check("spur_en_hold", longint'(v.exp_wr ? wr_en[u] : rd_en[u]), 1);
            end
        end
        push_cpl(u, v.exp_gnt, 1'b0);
        pulse_done(u, v.exp_wr);
        wait_cpl(u);
        check("vec_txn_cnt", get_cnt(u), model_cnt[u]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_cnt = '{0, 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t rr [4];
        vec_t w;
        int   n;
        int   wrap_exp [5] = '{1, 2, 3, 0, 1};

        rr[0] = '{2'b11, 2'b10, 5, 1'b1, 2'b01, 1'b0};
        rr[1] = '{2'b11, 2'b10, 3, 1'b0, 2'b10, 1'b1};
        rr[2] = '{2'b11, 2'b10, 7, 1'b0, 2'b01, 1'b0};
        rr[3] = '{2'b11, 2'b10, 2, 1'b0, 2'b10, 1'b1};
        w     = '{2'b01, 2'b00, 3, 1'b0, 2'b01, 1'b0};

        rst_n = 1'b0;
        model_cnt = '{0, 0};
        for (int u = 0; u < 2; u++) begin
            req[u] = '0; req_wr[u] = '0; rd_done[u] = 1'b0; wr_done[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_outputs", longint'({gnt[u], cpl[u], cpl_err[u], rd_en[u], wr_en[u], busy[u]}), 0);
            check("rst_txn_cnt", get_cnt(u), 0);
        end
        rst_n = 1'b1;

        // Single read, with spurious rd_done in IDLE and GAP, then min spacing.
        @(negedge clk);
        pulse_done(0, 1'b0);
        check("idle_done_busy", longint'(busy[0]), 0);
        req[0] = 2'b01; req_wr[0] = 2'b00;
        push_gnt(0, 2'b01, 1'b0);
        @(negedge clk);
        check("sr_gnt", longint'(gnt[0]), 1);
        check("sr_rd_en", longint'(rd_en[0]), 1);
        check("sr_busy", longint'(busy[0]), 1);
        req[0] = 2'b00;
        repeat (19) @(negedge clk);
        check("sr_hold", longint'(rd_en[0]), 1);
        push_cpl(0, 2'b01, 1'b0);
        pulse_done(0, 1'b0);
        check("sr_rd_fall", longint'(rd_en[0]), 0);
        check("sr_cpl", longint'(cpl[0]), 1);
        check("sr_cnt", get_cnt(0), 1);
        req[0] = 2'b01;
        pulse_done(0, 1'b0);
        push_gnt(0, 2'b01, 1'b0);
        repeat (GAP - 1) @(negedge clk);
        check("gap_busy_hi", longint'(busy[0]), 1);
        @(negedge clk);
        check("gap_busy_lo", longint'(busy[0]), 0);
        check("gap_rd_en_lo", longint'(rd_en[0]), 0);
        @(negedge clk);
        check("gap_spacing_rd_en", longint'(rd_en[0]), 1);
        req[0] = 2'b00;
        repeat (4) @(negedge clk);
        push_cpl(0, 2'b01, 1'b0);
        pulse_done(0, 1'b0);
        wait_cpl(0);
        check("sr2_cnt", get_cnt(0), 2);
        repeat (GAP + 2) @(negedge clk);

        // Round-robin with both requesters held.
        do_reset();
        for (int i = 0; i < 4; i++) run_vec(0, rr[i]);
        req[0] = 2'b00;
        check("rr_cnt", get_cnt(0), 4);
        repeat (GAP + 2) @(negedge clk);

        // Reset while a write is in flight.
        req[0] = 2'b01; req_wr[0] = 2'b01;
        push_gnt(0, 2'b01, 1'b1);
        wait_gnt(0);
        repeat (3) @(negedge clk);
        check("mid_wr_en_pre", longint'(wr_en[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", longint'(wr_en[0]), 0);
        check("mid_rst_busy", longint'(busy[0]), 0);
        check("mid_rst_gnt", longint'(gnt[0]), 0);
        check("mid_rst_cnt", get_cnt(0), 0);
        model_cnt = '{0, 0};
        req[0] = 2'b11; req_wr[0] = 2'b10;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, '{2'b11, 2'b10, 4, 1'b0, 2'b01, 1'b0});
        run_vec(0, '{2'b11, 2'b10, 4, 1'b0, 2'b10, 1'b1});
        req[0] = 2'b00;
        repeat (GAP + 2) @(negedge clk);

        // Timeout on unit 1 (TIMEOUT=16).
        req[1] = 2'b01; req_wr[1] = 2'b00;
        push_gnt(1, 2'b01, 1'b0);
        wait_gnt(1);
        req[1] = 2'b00;
        push_cpl(1, 2'b01, 1'b1);
        n = 0;
        while (rd_en[1] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_en_len", n, 16);
        check("to_cpl", longint'(cpl[1]), 1);
        check("to_cpl_err", longint'(cpl_err[1]), 1);
        check("to_cnt", get_cnt(1), 0);
        repeat (GAP + 2) @(negedge clk);

        // Counter wrap on unit 1 (CNT_W=2).
        for (int i = 0; i < 5; i++) begin
            run_vec(1, w);
            check("wrap_seq", get_cnt(1), wrap_exp[i]);
        end
        req[1] = 2'b00;
        repeat (GAP + 3) @(negedge clk);

        check("gnt_queue_empty", gq.size(), 0);
        check("cpl_queue_empty", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
